// File: rtl/gate_logic_pipe.sv
// gate_logic_pipe: registered two-operand logic unit.
// One of eight bitwise/reduction operations is applied to a and b on
// accept; the result and its zero/all-ones flags sit in a single output
// register behind a valid/ready handshake. A free-running counter tracks
// how many results the consumer has taken since reset.
module gate_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] cnt
);

    // Operation encodings
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_RAND = 3'b111;

    // Evaluate the selected operation. RAND places the AND-reduction of a
    // in bit 0 and clears the rest, which also works for WIDTH == 1.
    function automatic logic [WIDTH-1:0] gate_eval(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [2:0]       sel
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (sel)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_NOTA: r = ~x;
            OP_RAND: begin
                r    = '0;
                r[0] = &x;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Stage p0: combinational result and flags ahead of the output register
    logic [WIDTH-1:0] res_p0;
    logic             zero_p0;
    logic             ones_p0;
    logic             accept;
    logic             consume;

    // Next result and its flags, derived from the live operands
    always_comb begin
        res_p0  = gate_eval(a, b, op);
        zero_p0 = (res_p0 == '0);
        ones_p0 = &res_p0;
    end

    // The output register can take new data when empty or being drained
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;

    // Stage p1: output register, valid flag and consumed-result counter.
    // Everything clears on reset so no output is ever undefined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f         <= '0;
            zero      <= 1'b0;
            ones      <= 1'b0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                f         <= res_p0;
                zero      <= zero_p0;
                ones      <= ones_p0;
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
            if (consume) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gate_logic_pipe.sv
// tb_gate_logic_pipe: directed-vector bench for gate_logic_pipe.
// Two instances share all inputs: WIDTH=4/CNT_W=8 for the main checks and
// WIDTH=4/CNT_W=2 to observe counter wrap.
module tb_gate_logic_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;

    logic       in_ready,  out_valid,  zero,  ones;
    logic [3:0] f;
    logic [7:0] cnt;

    logic       in_ready2, out_valid2, zero2, ones2;
    logic [3:0] f2;
    logic [1:0] cnt2;

    int n_cmp;
    int n_bad;

    logic [3:0] tt_exp [8];
    logic [1:0] wrap_seq [5];

    gate_logic_pipe #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .zero(zero), .ones(ones), .cnt(cnt)
    );

    gate_logic_pipe #(.WIDTH(4), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
        .f(f2), .zero(zero2), .ones(ones2), .cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tt_exp[0] = 4'b1000; tt_exp[1] = 4'b1110; tt_exp[2] = 4'b0110; tt_exp[3] = 4'b0111;
        tt_exp[4] = 4'b0001; tt_exp[5] = 4'b1001; tt_exp[6] = 4'b0011; tt_exp[7] = 4'b0000;
        wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3; wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 4'h0; b = 4'h0; op = 3'd0;

        // Reset state, before any clock edge
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_f",         {28'd0, f},         32'd0);
        chk("rst_zero",      {31'd0, zero},      32'd0);
        chk("rst_ones",      {31'd0, ones},      32'd0);
        chk("rst_cnt",       {24'd0, cnt},       32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_cnt_w2",    {30'd0, cnt2},      32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Truth-table sweep: a=1100, b=1010, op 0..7, consumer always ready
        in_valid = 1'b1; out_ready = 1'b1; a = 4'b1100; b = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            cyc();
            chk($sformatf("tt_f_op%0d", i),    {28'd0, f},    {28'd0, tt_exp[i]});
            chk($sformatf("tt_zero_op%0d", i), {31'd0, zero}, (i == 7) ? 32'd1 : 32'd0);
            chk($sformatf("tt_ones_op%0d", i), {31'd0, ones}, 32'd0);
            chk($sformatf("tt_vld_op%0d", i),  {31'd0, out_valid}, 32'd1);
            chk($sformatf("tt_cnt_op%0d", i),  {24'd0, cnt},  32'(i));
        end
        in_valid = 1'b0;
        cyc();
        chk("tt_cnt_end",   {24'd0, cnt},       32'd8);
        chk("tt_vld_end",   {31'd0, out_valid}, 32'd0);
        chk("tt_f_hold",    {28'd0, f},         32'd0);
        chk("tt_cnt_w2",    {30'd0, cnt2},      32'd0);

        // Reduction and flags
        in_valid = 1'b1; op = 3'b111; a = 4'hF; b = 4'h0;
        cyc();
        chk("rand_f",    {28'd0, f},    32'h1);
        chk("rand_zero", {31'd0, zero}, 32'd0);
        chk("rand_ones", {31'd0, ones}, 32'd0);
        op = 3'b001; a = 4'hF; b = 4'h0;
        cyc();
        chk("or_f",    {28'd0, f},    32'hF);
        chk("or_ones", {31'd0, ones}, 32'd1);
        chk("or_zero", {31'd0, zero}, 32'd0);
        chk("or_cnt",  {24'd0, cnt},  32'd9);
        in_valid = 1'b0;
        cyc();
        chk("red_cnt_end", {24'd0, cnt}, 32'd10);

        // Back-pressure: accept F AND 0, then stall three cycles
        in_valid = 1'b1; op = 3'b000; a = 4'hF; b = 4'h0;
        cyc();
        chk("bp_f0",    {28'd0, f},         32'h0);
        chk("bp_zero0", {31'd0, zero},      32'd1);
        chk("bp_vld0",  {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 4'(i + 5); b = 4'h3; op = 3'(i + 1);
            #1;
            chk($sformatf("bp_rdy_%0d", i), {31'd0, in_ready}, 32'd0);
            cyc();
            chk($sformatf("bp_f_%0d", i),    {28'd0, f},         32'h0);
            chk($sformatf("bp_zero_%0d", i), {31'd0, zero},      32'd1);
            chk($sformatf("bp_vld_%0d", i),  {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_cnt_%0d", i),  {24'd0, cnt},       32'd10);
        end
        a = 4'h5; b = 4'h3; op = 3'b001; out_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("bp_cnt_rel", {24'd0, cnt},       32'd11);
        chk("bp_f_rel",   {28'd0, f},         32'h7);
        chk("bp_vld_rel", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        cyc();
        chk("bp_cnt_end", {24'd0, cnt},       32'd12);
        chk("bp_vld_end", {31'd0, out_valid}, 32'd0);
        chk("bp_f_end",   {28'd0, f},         32'h7);

        // Asynchronous reset mid-cycle while a result is held
        in_valid = 1'b1; out_ready = 1'b0; op = 3'b001; a = 4'hF; b = 4'h0;
        cyc();
        chk("ar_vld_pre", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld",  {31'd0, out_valid}, 32'd0);
        chk("ar_f",    {28'd0, f},         32'd0);
        chk("ar_ones", {31'd0, ones},      32'd0);
        chk("ar_zero", {31'd0, zero},      32'd0);
        chk("ar_cnt",  {24'd0, cnt},       32'd0);
        chk("ar_rdy",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming: a increments, f = a XOR 1010, one result per cycle
        in_valid = 1'b1; out_ready = 1'b1; op = 3'b010; b = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            a = 4'(i);
            cyc();
            chk($sformatf("st_vld_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("st_f_%0d", i),   {28'd0, f},         {28'd0, 4'(i) ^ 4'b1010});
        end
        in_valid = 1'b0;
        cyc();
        chk("st_cnt",    {24'd0, cnt},  32'd10);
        chk("st_cnt_w2", {30'd0, cnt2}, 32'd2);

        // Counter wrap on the CNT_W=2 instance
        rst_n = 1'b0;
        #1;
        chk("wr_rst_cnt_w2", {30'd0, cnt2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op = 3'b000; b = 4'hF;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; a = 4'(k);
            cyc();
            in_valid = 1'b0;
            cyc();
            chk($sformatf("wr_cnt_w2_%0d", k), {30'd0, cnt2}, {30'd0, wrap_seq[k]});
            chk($sformatf("wr_cnt_%0d", k),    {24'd0, cnt},  32'(k + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
